multi_debounce: RTL and testbench
=================================

// Module: multi_debounce
// PURPOSE
//  Parametrised multi-channel debouncer, successor to the single-button debouncer.
//  Debounces N_CH asynchronous push-button/switch inputs with one shared sample-tick prescaler.
//  Each channel has a synchroniser and its own 4-state debounce FSM.
//  Outputs per channel: debounced level, one-cycle press pulse and one-cycle release pulse.
//  Sits between board pins and game control logic (paddle up/down, start, pause).
// PARAMETERS
//  N_CH        4       number of independent input channels (>=1)
//  TICK_DIV    100000  clk cycles per sample tick (>=1; 1 => tick every cycle)
//  N_STABLE    10      consecutive ticks input must stay stable before db level changes (>=1)
//  SYNC_STAGES 2       flip-flop stages in each input synchroniser (>=2)
// PORTS
//  clk        in   1     system clock; all state on rising edge
//  reset      in   1     asynchronous, active-high reset
//  button_in  in   N_CH  raw asynchronous inputs, bit i = channel i
//  db_signal  out  N_CH  debounced level per channel (registered)
//  rise_pulse out  N_CH  1-cycle pulse on the cycle db_signal[i] goes 0->1
//  fall_pulse out  N_CH  1-cycle pulse on the cycle db_signal[i] goes 1->0
//  tick       out  1     shared sample tick, 1 cycle wide, for debug/other consumers
// BEHAVIOUR
//  Reset (async assert, sync to clk by design of use): sync chains=0, prescaler=0, tick=0,
//   every FSM=ZERO, stable counters=0, db_signal=0, rise_pulse=0, fall_pulse=0.
//  Synchroniser: SYNC_STAGES-deep FF chain per bit; s[i] = last stage. Adds SYNC_STAGES cycles latency.
//  Prescaler: counts 0..TICK_DIV-1, wraps to 0; tick=1 (registered) in the cycle after count==TICK_DIV-1,
//   i.e. exactly one cycle in every TICK_DIV. TICK_DIV=1 => tick held high after reset.
//  Per-channel FSM, counter cnt width $clog2(N_STABLE+1):
//   ZERO  : db=0. s=1 -> WAIT1, cnt<=0.
//   WAIT1 : s=0 (any cycle, tick or not) -> ZERO (glitch abort, no pulse).
//           s=1 & tick: cnt==N_STABLE-1 -> ONE; else cnt<=cnt+1.
//   ONE   : db=1. s=0 -> WAIT0, cnt<=0.
//   WAIT0 : s=1 (any cycle) -> ONE (abort, no pulse).
//           s=0 & tick: cnt==N_STABLE-1 -> ZERO; else cnt<=cnt+1.
//   db_signal registered from state: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
//  Pulses: rise_pulse[i]=1 exactly in the cycle db_signal[i] first reads 1 (WAIT1->ONE);
//   fall_pulse[i] likewise on WAIT0->ZERO. Never both high; never high for >1 cycle.
//  Latency: from s[i] change held stable, db changes after N_STABLE ticks, i.e. between
//   (N_STABLE-1)*TICK_DIV+1 and N_STABLE*TICK_DIV cycles (+1 output register), plus SYNC_STAGES.
//  Channels fully independent; simultaneous transitions on several channels allowed, same cycle.
//  Tick coinciding with the s change cycle: FSM enters WAIT1/WAIT0 that cycle; that tick not counted.
//  Reset mid-count: all FSMs to ZERO, db=0; a channel held high re-debounces from scratch, then raises rise_pulse.
//  No counter overflow: cnt never exceeds N_STABLE-1.
// TESTING (bench params: N_CH=2, TICK_DIV=4, N_STABLE=3, SYNC_STAGES=2)
//  1 Reset: assert reset with button_in=2'b11 -> db_signal=0, pulses=0, tick=0 during reset;
//    after release ch0/ch1 rise together after 2 sync + 9..12 stable cycles, one rise_pulse each.
//  2 Clean press ch0: button_in[0] 0->1 held 20 cycles -> db_signal[0]=1 within 15 cycles,
//    rise_pulse[0] exactly 1 cycle, db_signal[1]=0 throughout.
//  3 Bounce: toggle ch0 every 3 cycles for 30 cycles then hold 1 -> no db change/pulse during
//    toggling; db rises 11..15 cycles after last edge, single rise_pulse.
//  4 Release glitch: ch1 at db=1, drop to 0 for 5 cycles then back to 1 -> db_signal[1] stays 1,
//    fall_pulse[1] never asserted.
//  5 Independence: ch0 press and ch1 release in same cycle -> rise_pulse[0] and fall_pulse[1] in same cycle.
//  6 Tick check: count tick over 40 cycles -> exactly 10 pulses, period 4; mid-count reset -> db=0, FSM restarts.

Source files
------------

// File: rtl/multi_debounce.sv
// Debounces N_CH asynchronous buttons; one prescaler tick is shared by all channels.
// Latency: SYNC_STAGES + between (N_STABLE-1)*TICK_DIV+1 and N_STABLE*TICK_DIV cycles.
// Backpressure: none; the block is free-running and its outputs are always valid.
module multi_debounce #(
    parameter int N_CH        = 4,
    parameter int TICK_DIV    = 100000,
    parameter int N_STABLE    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] db_signal,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (N_STABLE > 1) ? $clog2(N_STABLE + 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_LAST = CW'(N_STABLE - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    // Stage 0 samples the pin; the last stage is the only one the FSMs may read.
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    logic [PW-1:0] pcnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
            tick   <= 1'b0;
        end else begin
            tick   <= (pcnt_q == P_LAST);
            pcnt_q <= (pcnt_q == P_LAST) ? '0 : pcnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          db_q, rise_q, fall_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ZERO: begin
                    if (s[i]) begin
                        state_d = WAIT1;
                        cnt_d   = '0;
                    end
                end
                WAIT1: begin
                    // Any return to the old level aborts, tick or not.
                    if (!s[i]) begin
                        state_d = ZERO;
                    end else if (tick) begin
                        if (cnt_q == C_LAST) state_d = ONE;
                        else                 cnt_d   = cnt_q + 1'b1;
                    end
                end
                ONE: begin
                    if (!s[i]) begin
                        state_d = WAIT0;
                        cnt_d   = '0;
                    end
                end
                WAIT0: begin
                    if (s[i]) begin
                        state_d = ONE;
                    end else if (tick) begin
                        if (cnt_q == C_LAST) state_d = ZERO;
                        else                 cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: state_d = ZERO;
            endcase
        end

        // Outputs are registered from the next state so level and pulse move together.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ZERO;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                db_q    <= (state_d == ONE) || (state_d == WAIT0);
                rise_q  <= (state_q == WAIT1) && (state_d == ONE);
                fall_q  <= (state_q == WAIT0) && (state_d == ZERO);
            end
        end

        assign db_signal[i]  = db_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed and random stimulus for multi_debounce, checked each cycle against a level/tick model.
module tb_multi_debounce;

    localparam int N_CH        = 2;
    localparam int TICK_DIV    = 4;
    localparam int N_STABLE    = 3;
    localparam int SYNC_STAGES = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] button_in;
    logic [N_CH-1:0] db_signal, rise_pulse, fall_pulse;
    logic            tick;

    always #5 clk = ~clk;

    multi_debounce #(
        .N_CH(N_CH), .TICK_DIV(TICK_DIV), .N_STABLE(N_STABLE), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset(reset), .button_in(button_in),
        .db_signal(db_signal), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .tick(tick)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a channel's level flips once the synchronised input has
    // differed from it for N_STABLE counted ticks; ticks fall on every TICK_DIV-th edge.
    int unsigned     edges;
    bit              m_tick;
    bit              m_db   [N_CH];
    bit              m_wait [N_CH];
    int              m_cnt  [N_CH];
    bit              m_rise [N_CH];
    bit              m_fall [N_CH];
    logic [N_CH-1:0] hist[$];

    // Observation counters for the directed scenarios.
    int rc[N_CH], fc[N_CH], dbhi[N_CH], nc, tick_n, bad_period, last_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        edges  = 0;
        m_tick = 1'b0;
        hist.delete();
        for (int c = 0; c < N_CH; c++) begin
            m_db[c] = 0; m_wait[c] = 0; m_cnt[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [N_CH-1:0] sv;
        sv = (hist.size() >= SYNC_STAGES) ? hist[SYNC_STAGES-1] : '0;
        for (int c = 0; c < N_CH; c++) begin
            m_rise[c] = 0;
            m_fall[c] = 0;
            if (!m_wait[c]) begin
                if (sv[c] != m_db[c]) begin
                    m_wait[c] = 1;
                    m_cnt[c]  = 0;
                end
            end else if (sv[c] == m_db[c]) begin
                m_wait[c] = 0;
            end else if (m_tick) begin
                m_cnt[c]++;
                if (m_cnt[c] == N_STABLE) begin
                    m_db[c]   = !m_db[c];
                    m_wait[c] = 0;
                    if (m_db[c]) m_rise[c] = 1;
                    else         m_fall[c] = 1;
                end
            end
        end
        edges++;
        m_tick = ((edges % TICK_DIV) == 0);
        hist.push_front(button_in);
        if (hist.size() > SYNC_STAGES) void'(hist.pop_back());
    endtask

    task automatic check_all(input string tag);
        logic [N_CH-1:0] e_db, e_r, e_f;
        for (int c = 0; c < N_CH; c++) begin
            e_db[c] = m_db[c]; e_r[c] = m_rise[c]; e_f[c] = m_fall[c];
        end
        check({tag, "_db"},   32'(db_signal),  32'(e_db));
        check({tag, "_rise"}, 32'(rise_pulse), 32'(e_r));
        check({tag, "_fall"}, 32'(fall_pulse), 32'(e_f));
        check({tag, "_tick"}, 32'(tick),       32'(m_tick));
    endtask

    task automatic clr();
        for (int c = 0; c < N_CH; c++) begin
            rc[c] = 0; fc[c] = 0; dbhi[c] = 0;
        end
        nc = 0; tick_n = 0; bad_period = 0; last_tick = -1;
    endtask

    // Called just after an edge: apply input, take one edge, compare #1 later.
    task automatic cyc(input logic [N_CH-1:0] b);
        button_in = b;
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_all("cyc");
        nc++;
        for (int c = 0; c < N_CH; c++) begin
            rc[c]   += int'(rise_pulse[c]);
            fc[c]   += int'(fall_pulse[c]);
            dbhi[c] += int'(db_signal[c]);
        end
        if (tick) begin
            if (last_tick >= 0 && nc - last_tick != TICK_DIV) bad_period++;
            last_tick = nc;
            tick_n++;
        end
    endtask

    task automatic run(input logic [N_CH-1:0] b, input int n);
        for (int k = 0; k < n; k++) cyc(b);
    endtask

    initial begin
        int lat, lat1, r0, f1;
        reset     = 1'b1;
        button_in = 2'b11;
        model_reset();
        clr();

        // 1: reset held with both inputs high, then both channels rise together.
        run(2'b11, 3);
        check("t1_db_in_reset", 32'(db_signal), 32'd0);
        reset = 1'b0;
        clr();
        lat = -1; lat1 = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc(2'b11);
            if (db_signal[0] && lat < 0)  lat  = k;
            if (db_signal[1] && lat1 < 0) lat1 = k;
        end
        check("t1_lat_window", 32'(lat >= 11 && lat <= 15), 32'd1);
        check("t1_same_cycle", 32'(lat1), 32'(lat));
        check("t1_rise0", 32'(rc[0]), 32'd1);
        check("t1_rise1", 32'(rc[1]), 32'd1);

        // 2: clean press on ch0 only.
        run(2'b00, 24);
        clr();
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc(2'b01);
            if (db_signal[0] && lat < 0) lat = k;
        end
        check("t2_lat_le15", 32'(lat > 0 && lat <= 15), 32'd1);
        check("t2_rise0", 32'(rc[0]), 32'd1);
        check("t2_ch1_low", 32'(dbhi[1]), 32'd0);

        // 3: bounce every 3 cycles, then hold high.
        run(2'b00, 24);
        clr();
        for (int seg = 0; seg < 10; seg++) run((seg % 2 == 0) ? 2'b01 : 2'b00, 3);
        check("t3_no_db", 32'(dbhi[0]), 32'd0);
        check("t3_no_pulse", 32'(rc[0] + fc[0]), 32'd0);
        clr();
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc(2'b01);
            if (db_signal[0] && lat < 0) lat = k;
        end
        check("t3_lat_window", 32'(lat >= 11 && lat <= 15), 32'd1);
        check("t3_single_rise", 32'(rc[0]), 32'd1);

        // 4: short release glitch on ch1.
        run(2'b11, 24);
        clr();
        run(2'b01, 5);
        run(2'b11, 20);
        check("t4_db1_held", 32'(dbhi[1]), 32'(nc));
        check("t4_no_fall1", 32'(fc[1]), 32'd0);

        // 5: ch0 press and ch1 release in the same cycle.
        run(2'b10, 24);
        clr();
        r0 = -1; f1 = -1;
        for (int k = 1; k <= 25; k++) begin
            cyc(2'b01);
            if (rise_pulse[0] && r0 < 0) r0 = k;
            if (fall_pulse[1] && f1 < 0) f1 = k;
        end
        check("t5_rise_seen", 32'(r0 > 0), 32'd1);
        check("t5_same_cycle", 32'(f1), 32'(r0));
        check("t5_one_fall", 32'(fc[1]), 32'd1);

        // 6: tick rate, then reset in the middle of a count.
        clr();
        run(2'b01, 40);
        check("t6_tick_count", 32'(tick_n), 32'd10);
        check("t6_tick_period", 32'(bad_period), 32'd0);
        run(2'b11, 24);
        run(2'b10, 6);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6_async_rst");
        run(2'b11, 2);
        reset = 1'b0;
        clr();
        run(2'b11, 24);
        check("t6_rerise0", 32'(rc[0]), 32'd1);
        check("t6_rerise1", 32'(rc[1]), 32'd1);
        check("t6_db_final", 32'(db_signal), 32'd3);

        // Random hold lengths spanning both sides of the debounce window.
        for (int seg = 0; seg < 40; seg++) begin
            run(2'($urandom_range(0, 3)), int'($urandom_range(1, 16)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
